// File: rtl/dibu_pkg.sv
// Shared definitions for the Dibu processor: control-vector layout, opcode
// constants, ALU op encodings and control-unit states.
package dibu_pkg;

    localparam int signals_size = 12;

    typedef logic [signals_size-1:0] signals_t;

    // Control-vector bit positions
    localparam int s_pc_inc     = 0;
    localparam int s_mar_w_en   = 1;
    localparam int s_reg_rw     = 2;
    localparam int s_alu_out_en = 3;
    localparam int s_flags_en   = 4;
    localparam int s_imm_en     = 5;
    localparam int s_dar_w_en   = 6;
    localparam int s_mdr_w_en   = 7;
    localparam int s_mem_w_en   = 8;
    localparam int s_mdr_out_en = 9;
    localparam int s_reg_to_mar = 10;
    localparam int s_flags_w_en = 11;

    localparam logic [1:0] OP_ALU_PREFIX = 2'b00;
    localparam logic [4:0] OP_MOVI       = 5'b01000;
    localparam logic [4:0] OP_LOAD       = 5'b01001;
    localparam logic [4:0] OP_STORE      = 5'b01010;
    localparam logic [4:0] OP_RDFLAGS    = 5'b01011;
    localparam logic [4:0] OP_HALT       = 5'b11111;

    // ALU operation carried in opcode[2:0]; decoded by the ALU block itself
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_NOT = 3'd5,
        ALU_SHL = 3'd6,
        ALU_SHR = 3'd7
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_F0   = 3'd0,
        ST_F1   = 3'd1,
        ST_EX1  = 3'd2,
        ST_LD2  = 3'd3,
        ST_LD3  = 3'd4,
        ST_LD4  = 3'd5,
        ST_ST2  = 3'd6,
        ST_HALT = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_MOVI,
        CLS_LOAD,
        CLS_STORE,
        CLS_RDFLAGS,
        CLS_HALT,
        CLS_NOP
    } op_class_e;

    function automatic op_class_e decode_class(input logic [4:0] opcode);
        op_class_e cls;
        if (opcode[4:3] == OP_ALU_PREFIX) begin
            cls = CLS_ALU;
        end else begin
            case (opcode)
                OP_MOVI:    cls = CLS_MOVI;
                OP_LOAD:    cls = CLS_LOAD;
                OP_STORE:   cls = CLS_STORE;
                OP_RDFLAGS: cls = CLS_RDFLAGS;
                OP_HALT:    cls = CLS_HALT;
                default:    cls = CLS_NOP;
            endcase
        end
        return cls;
    endfunction

    function automatic signals_t sig_bit(input int idx);
        return signals_t'(1) << idx;
    endfunction

endpackage

// File: rtl/dibu_ctrl_unit_if.sv
// Control-unit bus: advance enable and opcode in, control vector and halt
// status out.
interface dibu_ctrl_unit_if;
    import dibu_pkg::*;

    logic       run;
    logic [4:0] opcode;
    signals_t   signals;
    logic       halted;

    // Sequencer-facing side (drives run/opcode, consumes the control vector)
    modport master (
        output run,
        output opcode,
        input  signals,
        input  halted
    );

    // Control unit side
    modport slave (
        input  run,
        input  opcode,
        output signals,
        output halted
    );

endinterface

// File: rtl/dibu_microcode_rom.sv
// Combinational microcode: maps (state, opcode) to the control vector and the
// next micro-state. Opcode only matters in EX1.
module dibu_microcode_rom
    import dibu_pkg::*;
(
    input  state_e     state,
    input  logic [4:0] opcode,
    output signals_t   signals,
    output state_e     next_state
);

    op_class_e op_class;

    assign op_class = decode_class(opcode);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        signals    = '0;
        next_state = ST_F0;

        case (state)
            ST_F0: begin
                signals    = sig_bit(s_mar_w_en) | sig_bit(s_pc_inc);
                next_state = ST_F1;
            end

            // Code memory read in flight; IR becomes valid at the end of F1
            ST_F1: begin
                next_state = ST_EX1;
            end

            ST_EX1: begin
                case (op_class)
                    CLS_ALU: begin
                        signals = sig_bit(s_alu_out_en) | sig_bit(s_reg_rw)
                                | sig_bit(s_flags_w_en);
                    end
                    CLS_MOVI: begin
                        signals = sig_bit(s_imm_en) | sig_bit(s_reg_rw);
                    end
                    CLS_RDFLAGS: begin
                        signals = sig_bit(s_flags_en) | sig_bit(s_reg_rw);
                    end
                    CLS_LOAD: begin
                        signals    = sig_bit(s_dar_w_en);
                        next_state = ST_LD2;
                    end
                    CLS_STORE: begin
                        signals    = sig_bit(s_dar_w_en) | sig_bit(s_mdr_w_en)
                                   | sig_bit(s_reg_to_mar);
                        next_state = ST_ST2;
                    end
                    CLS_HALT: begin
                        next_state = ST_HALT;
                    end
                    default: begin
                        next_state = ST_F0;
                    end
                endcase
            end

            // Data memory read latency
            ST_LD2: begin
                next_state = ST_LD3;
            end

            // reg_to_mar stays low so the MDR captures memory data, not a register
            ST_LD3: begin
                signals    = sig_bit(s_mdr_w_en);
                next_state = ST_LD4;
            end

            ST_LD4: begin
                signals    = sig_bit(s_mdr_out_en) | sig_bit(s_reg_rw);
                next_state = ST_F0;
            end

            ST_ST2: begin
                signals    = sig_bit(s_mem_w_en);
                next_state = ST_F0;
            end

            ST_HALT: begin
                next_state = ST_HALT;
            end

            default: begin
                next_state = ST_F0;
            end
        endcase
    end

endmodule

// File: rtl/dibu_ctrl_unit.sv
// Dibu control unit: micro-state register with synchronous reset and run
// gating around the microcode ROM.
module dibu_ctrl_unit
    import dibu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    dibu_ctrl_unit_if.slave bus
);

    state_e   state_q;
    state_e   state_d;
    state_e   rom_next;
    signals_t rom_signals;
    signals_t signals_out;

    dibu_microcode_rom u_rom (
        .state      (state_q),
        .opcode     (bus.opcode),
        .signals    (rom_signals),
        .next_state (rom_next)
    );

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples the pre-edge value regardless of process ordering.
        if (rst) begin
            state_q <= ST_F0;
        end else begin
            state_q <= state_d;
        end
    end

    // run low freezes the state and suppresses every write strobe; reset
    // forces the vector to zero so an abandoned instruction issues nothing.
    always_comb begin
        state_d     = state_q;
        signals_out = '0;
        if (bus.run) begin
            state_d     = rom_next;
            signals_out = rom_signals;
        end
        if (rst) begin
            signals_out = '0;
        end
    end

    assign bus.signals = signals_out;
    // Decoded straight from the state flop, so it rises the cycle after the
    // EX1 that saw HALT and is masked while reset is held.
    assign bus.halted  = (state_q == ST_HALT) && !rst;

endmodule

// File: tb/tb_dibu_ctrl_unit.sv
// Directed scoreboard bench for dibu_ctrl_unit: stimulus queues the expected
// per-cycle control vector, a negedge monitor pops and compares.
module tb_dibu_ctrl_unit;

    typedef struct {
        logic [11:0] sig;
        logic        halt;
        int          idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dibu_ctrl_unit_if bus ();

    dibu_ctrl_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec    = 0;
    int   n_miss   = 0;
    int   n_pushed = 0;

    task automatic check(input string name, input int idx,
                         input logic [11:0] act, input logic [11:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s vector %0d: got 0x%03h, expected 0x%03h",
                     name, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue what the DUT must show in that cycle
    task automatic step(input logic r, input logic ru, input logic [4:0] op,
                        input logic [11:0] es, input logic eh);
        exp_t e;
        rst        = r;
        bus.run    = ru;
        bus.opcode = op;
        e.sig  = es;
        e.halt = eh;
        e.idx  = n_pushed;
        exp_q.push_back(e);
        n_pushed++;
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are stable mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                n_vec++;
                check("signals", mon_e.idx, bus.signals, mon_e.sig);
                check("halted", mon_e.idx, {11'b0, bus.halted}, {11'b0, mon_e.halt});
            end
        end
    end

    initial begin
        rst        = 1'b1;
        bus.run    = 1'b1;
        bus.opcode = 5'b01000;
        @(posedge clk);
        #1;

        // Reset held two cycles with a live MOVI opcode
        step(1, 1, 5'b01000, 12'h000, 0);
        step(1, 1, 5'b01000, 12'h000, 0);

        // MOVI
        step(0, 1, 5'b01000, 12'h003, 0);
        step(0, 1, 5'b01000, 12'h000, 0);
        step(0, 1, 5'b01000, 12'h024, 0);

        // ALU op 011, with a stale HALT opcode in F0/F1 that must be ignored
        step(0, 1, 5'b11111, 12'h003, 0);
        step(0, 1, 5'b11111, 12'h000, 0);
        step(0, 1, 5'b00011, 12'h80C, 0);

        // RDFLAGS
        step(0, 1, 5'b00011, 12'h003, 0);
        step(0, 1, 5'b00011, 12'h000, 0);
        step(0, 1, 5'b01011, 12'h014, 0);

        // LOAD: 6-cycle latency
        step(0, 1, 5'b01011, 12'h003, 0);
        step(0, 1, 5'b01011, 12'h000, 0);
        step(0, 1, 5'b01001, 12'h040, 0);
        step(0, 1, 5'b01001, 12'h000, 0);
        step(0, 1, 5'b01001, 12'h080, 0);
        step(0, 1, 5'b01001, 12'h204, 0);

        // STORE: 4-cycle latency
        step(0, 1, 5'b01001, 12'h003, 0);
        step(0, 1, 5'b01001, 12'h000, 0);
        step(0, 1, 5'b01010, 12'h4C0, 0);
        step(0, 1, 5'b01010, 12'h100, 0);

        // Unused opcode acts as NOP
        step(0, 1, 5'b01010, 12'h003, 0);
        step(0, 1, 5'b01010, 12'h000, 0);
        step(0, 1, 5'b10101, 12'h000, 0);

        // LOAD with run dropped for 3 cycles in LD3
        step(0, 1, 5'b10101, 12'h003, 0);
        step(0, 1, 5'b10101, 12'h000, 0);
        step(0, 1, 5'b01001, 12'h040, 0);
        step(0, 1, 5'b01001, 12'h000, 0);
        step(0, 0, 5'b01001, 12'h000, 0);
        step(0, 0, 5'b01001, 12'h000, 0);
        step(0, 0, 5'b01001, 12'h000, 0);
        step(0, 1, 5'b01001, 12'h080, 0);
        step(0, 1, 5'b01001, 12'h204, 0);

        // STORE abandoned by reset in ST2: no mem_w_en may appear
        step(0, 1, 5'b01001, 12'h003, 0);
        step(0, 1, 5'b01001, 12'h000, 0);
        step(0, 1, 5'b01010, 12'h4C0, 0);
        step(1, 1, 5'b01010, 12'h000, 0);

        // HALT, including run low while halted, then reset out of it
        step(0, 1, 5'b01010, 12'h003, 0);
        step(0, 1, 5'b01010, 12'h000, 0);
        step(0, 1, 5'b11111, 12'h000, 0);
        step(0, 1, 5'b11111, 12'h000, 1);
        step(0, 1, 5'b01000, 12'h000, 1);
        step(0, 0, 5'b01000, 12'h000, 1);
        step(0, 1, 5'b00011, 12'h000, 1);
        step(1, 1, 5'b00011, 12'h000, 0);
        step(0, 1, 5'b00011, 12'h003, 0);
        step(0, 1, 5'b00011, 12'h000, 0);
        step(0, 1, 5'b10101, 12'h000, 0);
        step(0, 1, 5'b10101, 12'h003, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        if (exp_q.size() > 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0",
                     exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
